mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multicycle sequencer for the MIPS datapath. Drives the datapath's control signals across FETCH/DECODE/execute states, one instruction at a time.
- Adds a memory-ready handshake with wait states and a watchdog timeout, so the shared instruction/data memory may take a variable number of cycles.
- Sits between the instruction register's opcode field and the datapath muxes, register file and memory.

Parameters:
- MEM_TIMEOUT, 15, max consecutive cycles with MemReady=0 in any memory state before abort (must be >=1)
- CNT_W, 4, timeout counter width; must satisfy 2**CNT_W > MEM_TIMEOUT

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Opcode  input  6  IR[31:26]; stable from DECODE until instruction completes
- MemReady  input  1  memory access completes this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- IorD  output  1  0=PC address, 1=ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load IR
- MemtoReg  output  1  1=MDR to register write data
- RegDst  output  1  1=rd, 0=rt
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct
- PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
- IllegalOp  output  1  one-cycle pulse: unsupported opcode in DECODE
- MemErr  output  1  sticky: memory timeout occurred
- State  output  4  current state, for debug

Behaviour:
- Moore outputs decoded from the registered state. Exceptions: IRWrite/PCWrite in FETCH and IllegalOp are gated combinationally by inputs as listed.
- Reset low (async): State=IDLE, timeout counter=0, MemErr=0, all outputs 0. Reset mid-instruction aborts it with no further writes.
- Encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- Unlisted outputs are 0 in every state.
- IDLE: all outputs 0 -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - MemReady=1 -> DECODE; otherwise stay (wait state).
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 0x23 or 0x2b -> MEMADR
  - 0x00 -> EXEC
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - else -> FETCH with IllegalOp=1 this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. 0x23 -> MEMRD; 0x2b -> MEMWR.
- MEMRD: MemRead=1, IorD=1. MemReady -> MEMWB; otherwise stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. MemReady -> FETCH; otherwise stay.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- Zero-wait latencies in cycles, counted FETCH through last state: lw 5, sw 4, R-type 4, beq 3, j 3. Each wait cycle adds 1.
- Timeout counter: cleared on entry to FETCH/MEMRD/MEMWR and whenever MemReady=1. Increments each cycle in those states while MemReady=0.
- Abort: if MemReady=0 and counter==MEM_TIMEOUT-1 -> next state IDLE, MemErr set. The aborted cycle issues no IRWrite/PCWrite/RegWrite.
- MemErr stays 1 until Reset.
- MemReady=1 on the timeout cycle: MemReady wins; normal transition, no error.

Optional Feature:
- Macro ADDI_EN.
- Defined: DECODE with Opcode 0x08 -> ADDIEX, then ADDIWB, then FETCH (4 cycles total).
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
- Undefined: 0x08 is illegal (IllegalOp pulse, -> FETCH). States 11/12 unreachable.

Test Plan:
- Reset low, then release; MemReady=1 -> State 0 then 1; all outputs 0 during reset. Cycle 2: MemRead=1, IRWrite=1, PCWrite=1.
- MemReady=1; Opcode 0x23 -> states 1,2,3,4,5,1. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Repeat with 0x00 -> 1,2,7,8,1 with RegDst=1, ALUOp=10 in EXEC.
- Opcode 0x2b, MemReady low 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, RegWrite never 1, then FETCH. Opcode 0x04 -> PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH.
- Opcode 0x3f -> IllegalOp=1 for exactly one cycle in DECODE, next State=1, no write enables asserted.
- MEM_TIMEOUT=15, MemReady=0 in FETCH -> 15 FETCH cycles with IRWrite=0, then State=0 and MemErr=1. MemErr stays 1 after later successful fetches until Reset. MemReady=1 on the 15th cycle -> DECODE, MemErr=0.
- Reset asserted in MEMRD -> State=0 immediately, MemRead=0. With ADDI_EN: 0x08 -> states 1,2,11,12,1, RegWrite=1 only in 12. Without ADDI_EN: IllegalOp pulse.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control sequencer with memory-ready wait states and a
// watchdog that aborts to IDLE (sticky MemErr) when memory stalls too long.
// Optional macro ADDI_EN adds the addi instruction (ADDIEX/ADDIWB states).
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic       MemErr,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Last stalled cycle allowed before the watchdog fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mem_err;
  logic             mem_state;
  logic             abort;
  logic             op_known;

  // States that talk to the shared memory and are covered by the watchdog.
  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // MemReady on the final allowed cycle wins over the timeout.
  assign abort     = mem_state && !MemReady && (cnt == CNT_LAST);

  assign MemErr = mem_err;
  assign State  = state;

  // Opcodes this sequencer knows how to execute.
  always_comb begin
    op_known = 1'b0;
    case (Opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_known = 1'b1;
`ifdef ADDI_EN
      OP_ADDI:                              op_known = 1'b1;
`endif
      default:                              op_known = 1'b0;
    endcase
  end

  // State, watchdog counter and sticky error registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (abort) begin
        mem_err <= 1'b1;
      end
    end
  end

  // Next-state selection and watchdog counter update.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      state_nxt = S_ADDIEX;
`endif
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  state_nxt = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_RWB;
      S_RWB:    state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_ADDIWB: state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
    end
    // Count only consecutive stalled cycles inside one memory state; any
    // entry, completion or abort restarts from zero.
    if (mem_state && !MemReady && (state_nxt == state)) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = '0;
    end
  end

  // Datapath control decoded from the registered state.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC+4 are only committed once the fetch data is valid.
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = !op_known;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: each driven cycle pushes the
// expected state and control word; a negedge monitor pops and compares.
module tb_mips_multicycle_control;

  logic       CLK;
  logic       Reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp, MemErr;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  mips_multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .MemErr(MemErr),
    .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [17:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, IllegalOp, MemErr};

  typedef struct {
    int          st;
    logic [17:0] ctl;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_merr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s (check %0d): got 0x%0h, want 0x%0h", tag, n_chk, got, want);
  endtask

  // Expected control word per state, written straight from the state table.
  function automatic logic [17:0] ctl(input int st, input logic mr, input logic ill, input logic merr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      2:  begin asb = 2'b11; end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rdst = 1; rw = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: begin rw = 1; end
      default: begin end
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, merr};
  endfunction

  // Drive one cycle's inputs, record what the DUT must show, advance.
  task automatic cyc(input logic [5:0] op, input logic mr, input int st, input logic ill);
    exp_t e;
    Opcode   = op;
    MemReady = mr;
    e.st  = st;
    e.ctl = ctl(st, mr, ill, exp_merr);
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("state", 32'(State), 32'(mon_e.st));
      check("ctl", 32'(obs), 32'(mon_e.ctl));
    end
  end

  initial begin
    Reset = 1'b0; MemReady = 1'b1; Opcode = 6'h3f;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_outs", 32'(obs), 32'd0);
    Reset = 1'b1;

    // lw, zero wait
    cyc(6'h23, 1, 0, 0);
    cyc(6'h23, 1, 1, 0); cyc(6'h23, 1, 2, 0); cyc(6'h23, 1, 3, 0);
    cyc(6'h23, 1, 4, 0); cyc(6'h23, 1, 5, 0);
    // R-type
    cyc(6'h00, 1, 1, 0); cyc(6'h00, 1, 2, 0); cyc(6'h00, 1, 7, 0); cyc(6'h00, 1, 8, 0);
    // sw with three wait cycles in MEMWR
    cyc(6'h2b, 1, 1, 0); cyc(6'h2b, 1, 2, 0); cyc(6'h2b, 1, 3, 0);
    cyc(6'h2b, 0, 6, 0); cyc(6'h2b, 0, 6, 0); cyc(6'h2b, 0, 6, 0); cyc(6'h2b, 1, 6, 0);
    // beq, j
    cyc(6'h04, 1, 1, 0); cyc(6'h04, 1, 2, 0); cyc(6'h04, 1, 9, 0);
    cyc(6'h02, 1, 1, 0); cyc(6'h02, 1, 2, 0); cyc(6'h02, 1, 10, 0);
    // illegal opcode
    cyc(6'h3f, 1, 1, 0); cyc(6'h3f, 1, 2, 1);
    // addi
`ifdef ADDI_EN
    cyc(6'h08, 1, 1, 0); cyc(6'h08, 1, 2, 0); cyc(6'h08, 1, 11, 0); cyc(6'h08, 1, 12, 0);
`else
    cyc(6'h08, 1, 1, 0); cyc(6'h08, 1, 2, 1);
`endif
    // lw with fetch and read wait states
    cyc(6'h23, 0, 1, 0); cyc(6'h23, 0, 1, 0); cyc(6'h23, 1, 1, 0);
    cyc(6'h23, 1, 2, 0); cyc(6'h23, 1, 3, 0);
    cyc(6'h23, 0, 4, 0); cyc(6'h23, 0, 4, 0); cyc(6'h23, 1, 4, 0); cyc(6'h23, 1, 5, 0);

    // fetch timeout: 15 stalled FETCH cycles, then IDLE with sticky MemErr
    for (int i = 0; i < 15; i++) cyc(6'h02, 0, 1, 0);
    exp_merr = 1'b1;
    cyc(6'h02, 1, 0, 0);
    cyc(6'h02, 1, 1, 0); cyc(6'h02, 1, 2, 0); cyc(6'h02, 1, 10, 0);
    // read timeout inside MEMRD
    cyc(6'h23, 1, 1, 0); cyc(6'h23, 1, 2, 0); cyc(6'h23, 1, 3, 0);
    for (int i = 0; i < 15; i++) cyc(6'h23, 0, 4, 0);
    cyc(6'h23, 1, 0, 0);

    // async reset while in MEMRD
    cyc(6'h23, 1, 1, 0); cyc(6'h23, 1, 2, 0); cyc(6'h23, 1, 3, 0);
    MemReady = 1'b0;
    check("pre_rst_memrd", 32'(State), 32'd4);
    #1;
    Reset = 1'b0;
    #1;
    check("midrst_state", 32'(State), 32'd0);
    check("midrst_memread", 32'(MemRead), 32'd0);
    check("midrst_outs", 32'(obs), 32'd0);
    exp_merr = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_hold_outs", 32'(obs), 32'd0);
    Reset = 1'b1;

    // ready on the 15th stalled fetch cycle: no error, normal decode
    cyc(6'h04, 1, 0, 0);
    for (int i = 0; i < 14; i++) cyc(6'h04, 0, 1, 0);
    cyc(6'h04, 1, 1, 0);
    cyc(6'h04, 1, 2, 0); cyc(6'h04, 1, 9, 0); cyc(6'h04, 1, 1, 0);

    @(negedge CLK);
    #1;
    check("drain_q", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
